matrix_mult_driver: RTL

MATRIX_MULT_DRIVER -- requirements
Module: matrix_mult_driver

---
 rtl/matrix_mult_driver.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_mult_driver.sv
// matrix_mult_driver
// Drives a 4x4 matrix-multiplier slave over a zero-wait-state Avalon-MM port.
// One job runs as follows:
//   1. Pulse the slave clear bit.
//   2. Stream N_IN operand words into the slave FIFO, with one idle cycle
//      after every write.
//   3. Write the go bit.
//   4. Poll the control register until done is set, or until TIMEOUT polls
//      have been made.
//   5. Read N_OUT result words and hand them downstream on a valid/ready
//      stream.
//
// Slave register map (mm_address):
//   00  control/status. Write: bit0 clear, bit1 go. Read: bit2 done, bit3 overflow.
//   01  operand FIFO (write only)
//   10  result FIFO (read pops one word)
//
// Ports:
//   clock, reset                      single clock, async active-high reset
//   job_start                         one-cycle job request, honoured only in IDLE
//   in_data/in_valid/in_ready         operand stream (16 A then 16 B, row-major)
//   out_data/out_valid/out_ready      result stream, C11..C44
//   mm_address/mm_writedata/
//   mm_write/mm_read/mm_readdata      Avalon-MM master; readdata valid same cycle
//   busy                              high in every state except IDLE
//   job_done                          one-cycle pulse on successful completion
//   overflow_flag                     slave overflow bit seen on the done poll
//   timeout_err                       sticky poll-timeout flag, cleared by the next job
module matrix_mult_driver #(
    parameter int N_IN    = 32,
    parameter int N_OUT   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        job_start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  mm_address,
    output logic [31:0] mm_writedata,
    output logic        mm_write,
    output logic        mm_read,
    input  logic [31:0] mm_readdata,
    output logic        busy,
    output logic        job_done,
    output logic        overflow_flag,
    output logic        timeout_err
);

    // Counters are wide enough to hold their terminal value without wrapping.
    localparam int LW = $clog2(N_IN + 1);
    localparam int DW = $clog2(N_OUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0]  ADDR_CTRL = 2'b00;
    localparam logic [1:0]  ADDR_DATA = 2'b01;
    localparam logic [1:0]  ADDR_RES  = 2'b10;
    localparam logic [31:0] CTRL_CLR  = 32'h0000_0001;
    localparam logic [31:0] CTRL_GO   = 32'h0000_0002;
    localparam logic [31:0] CTRL_NONE = 32'h0000_0000;

    typedef enum logic [3:0] {
        IDLE,
        CLR_SET,
        CLR_REL,
        LOAD_WR,
        LOAD_GAP,
        START,
        POLL,
        DRAIN,
        FINISH
    } state_t;

    state_t        state;
    logic [LW-1:0] load_cnt;
    logic [DW-1:0] drain_cnt;
    logic [TW-1:0] poll_cnt;
    // When set, FINISH is the exit path after a poll timeout. On that path
    // FINISH issues the slave clear write instead of the job_done pulse.
    logic          aborting;

    // ------------------------------------------------------------------
    // Control FSM. All state and the registered status outputs are updated
    // here.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            load_cnt      <= '0;
            drain_cnt     <= '0;
            poll_cnt      <= '0;
            aborting      <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            job_done      <= 1'b0;
            overflow_flag <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            job_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_start) begin
                        state         <= CLR_SET;
                        load_cnt      <= '0;
                        drain_cnt     <= '0;
                        poll_cnt      <= '0;
                        aborting      <= 1'b0;
                        overflow_flag <= 1'b0;
                        timeout_err   <= 1'b0;
                    end
                end
                CLR_SET: state <= CLR_REL;
                CLR_REL: state <= LOAD_WR;
                LOAD_WR: begin
                    // The bus write is issued combinationally in this same
                    // cycle. Here we only account for it.
                    if (in_valid) begin
                        load_cnt <= load_cnt + LW'(1);
                        state    <= LOAD_GAP;
                    end
                end
                LOAD_GAP: begin
                    state <= (load_cnt == LW'(N_IN)) ? START : LOAD_WR;
                end
                START: begin
                    poll_cnt <= '0;
                    state    <= POLL;
                end
                POLL: begin
                    // Done takes priority, including on the final allowed poll.
                    if (mm_readdata[2]) begin
                        overflow_flag <= mm_readdata[3];
                        state         <= DRAIN;
                    end else if (poll_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        aborting    <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        poll_cnt <= poll_cnt + TW'(1);
                    end
                end
                DRAIN: begin
                    // A one-word holding register. A new read is issued only
                    // while the register is empty, so out_data stays put
                    // under backpressure.
                    if (!out_valid) begin
                        out_data  <= mm_readdata;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        drain_cnt <= drain_cnt + DW'(1);
                        if (drain_cnt == DW'(N_OUT - 1)) begin
                            state    <= FINISH;
                            job_done <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    aborting <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus and handshake decode. Everything defaults to zero, so mm_address
    // and mm_writedata read as 0 whenever no bus cycle is in progress. Read
    // and write are never issued from the same state.
    // ------------------------------------------------------------------
    always_comb begin
        mm_address   = ADDR_CTRL;
        mm_writedata = CTRL_NONE;
        mm_write     = 1'b0;
        mm_read      = 1'b0;
        in_ready     = 1'b0;
        case (state)
            CLR_SET: begin
                mm_write     = 1'b1;
                mm_writedata = CTRL_CLR;
            end
            CLR_REL: begin
                mm_write     = 1'b1;
                mm_writedata = CTRL_NONE;
            end
            LOAD_WR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mm_write     = 1'b1;
                    mm_address   = ADDR_DATA;
                    mm_writedata = in_data;
                end
            end
            START: begin
                mm_write     = 1'b1;
                mm_writedata = CTRL_GO;
            end
            POLL: begin
                mm_read = 1'b1;
            end
            DRAIN: begin
                if (!out_valid) begin
                    mm_read    = 1'b1;
                    mm_address = ADDR_RES;
                end
            end
            FINISH: begin
                if (aborting) begin
                    mm_write     = 1'b1;
                    mm_writedata = CTRL_CLR;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
